gb_cpu_interrupt_ctrl: RTL and testbench
========================================

Name: gb_cpu_interrupt_ctrl

Overview:
Interrupt and HALT controller for the Game Boy CPU.
- Holds IF (0xFF0F), IE (0xFFFF) and IME.
- Applies the EI one-instruction delay.
- At each instruction boundary, decides whether the next decoded "instruction" is the ISR schedule, and drives the decoder's isr_cmd input.
- Owns the HALT sleep/wake sequencing and the halt-bug indication consumed by the fetch logic.

Parameters:
NUM_IRQ, 5, number of interrupt sources; bit 0 is highest priority (VBlank, LCD, Timer, Serial, Joypad).
VEC_BASE, 8'h40, vector of source 0; source n vectors to VEC_BASE + 8*n.

Ports:
clk  in  1  CPU clock
rst  in  1  asynchronous, active-high reset
irq_in  in  NUM_IRQ  one-cycle set pulses from peripherals
bus_addr  in  16  CPU data-bus address
bus_wdata  in  8  write data
bus_we  in  1  write strobe, one cycle per write
bus_rdata  out  8  combinational read data for IF/IE
bus_hit  out  1  bus_addr is 0xFF0F or 0xFFFF
instr_boundary  in  1  last cycle of the current instruction; the next opcode is decoded on the following cycle
ei_exec, di_exec, reti_exec, halt_exec  in  1 each  asserted only in the same cycle as that instruction's instr_boundary
isr_ack  in  1  pulse from the ISR schedule cycle that loads the vector
isr_cmd  out  1  to decoder: execute the ISR schedule next
isr_vector  out  8  low byte of the jump target; high byte is 0x00
ime  out  1  current IME
halted  out  1  CPU is stalled in HALT
halt_bug  out  1  one-cycle pulse; fetch must not increment PC for the next opcode

Behaviour:
Reset values (rst=1, async): IF=0, IE=0, ime=0, ei_pend=0, isr_cmd=0, isr_vector=0x00, halted=0, halt_bug=0, state=RUN.

Registers:
- Write to 0xFF0F: IF <= wdata[4:0].
- Write to 0xFFFF: IE <= wdata (all 8 bits).
- Read of IF returns {3'b111, IF}. Read of IE returns IE. Otherwise bus_rdata=0x00.
- irq_in bits are ORed into IF every cycle.
- Same-cycle conflicts on one IF bit: irq_in set beats a bus write of 0 and beats the ack clear.
- pending = IE[4:0] & IF. any_pend = |pending.

IME:
- ime_eff = (ime | ei_pend | reti_exec) & ~di_exec, evaluated at instr_boundary.
- ei_exec: ei_pend <= 1 and ime is unchanged. As a result, the instruction following EI cannot be interrupted.
- At the next instr_boundary with ei_pend: ime <= 1, ei_pend <= 0.
- di_exec: ime <= 0, ei_pend <= 0.
- reti_exec: ime <= 1.
- Repeated EI keeps ei_pend set with no extra delay.

State machine (RUN, HALT, ISR):
- RUN, instr_boundary & ime_eff & any_pend & ~halt_exec:
  - isr_cmd <= 1, ime <= 0, ei_pend <= 0.
  - Go to ISR.
- RUN, instr_boundary & halt_exec:
  - If ~ime_eff & any_pend: halt_bug <= 1 for one cycle; stay in RUN.
  - Else: halted <= 1; go to HALT. If ime_eff, update ime as above.
- HALT:
  - instr_boundary is ignored.
  - When any_pend: halted <= 0 on the next edge (1-cycle wake latency).
  - If ime: isr_cmd <= 1, ime <= 0, go to ISR. Else go to RUN; the next opcode is fetched normally.
- ISR:
  - isr_cmd stays 1 until isr_ack.
  - On isr_ack, choose the lowest-index pending bit n from the current (not latched) pending set: isr_vector <= VEC_BASE+8n, IF[n] <= 0.
  - If none is pending at ack (IE/IF cleared meanwhile): isr_vector <= 0x00 and no IF bit is cleared.
  - isr_cmd <= 0; go to RUN.
  - isr_vector holds until the next ack.
- Reset asserted in any state returns all state to reset values immediately.

Decomposition:
- gb_cpu_common_pkg gains:
  - the irq_bit_t enum (IRQ_VBLANK..IRQ_JOYPAD);
  - localparams IF_ADDR=16'hFF0F, IE_ADDR=16'hFFFF, VEC_BASE;
  - the irq_state_t enum {RUN, HALT, ISR}.
- One sub-module, gb_cpu_irq_priority: a combinational lowest-index-first encoder with inputs pending[NUM_IRQ-1:0] and outputs valid and idx[2:0]. It is reused for the ack vector and the any_pend test.

Test Plan:
- Reset then irq_in=5'b00100, IE=0x04, ime=1, instr_boundary → next cycle isr_cmd=1, ime=0; isr_ack → isr_vector=0x50, IF=0x00, bus read of 0xFF0F=0xE0.
- IF=0x1F, IE=0x1F, ime=1, boundary+ack → vector 0x40 and IF=0x1E; repeat → 0x48, 0x50, 0x58, 0x60 in order.
- Pending IRQ, EI at boundary B0 → no isr_cmd after B0; isr_cmd=1 after the following boundary B1. DI at B1 instead → no isr_cmd and ime=0.
- HALT with ime=0, IE=0x01, IF=0 → halted=1; irq_in[0] pulse → halted=0 on the next cycle, isr_cmd stays 0, IF=0x01. Repeat with ime=1 → isr_cmd=1.
- HALT with ime=0 and IF&IE=0x02 already pending → halted stays 0, halt_bug=1 for exactly one cycle.
- Same-cycle cases:
  - bus write 0x00 to 0xFF0F together with irq_in=0x01 → IF=0x01.
  - With isr_cmd high, software writes IE=0 before ack → ack gives isr_vector=0x00 and IF unchanged.
  - rst pulsed while in ISR → isr_cmd=0, IF=0, IE=0.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared definitions for the Game Boy CPU: interrupt sources, register
// addresses, interrupt controller states and the vector helper.
package gb_cpu_common_pkg;

    // Interrupt sources in priority order, bit 0 highest.
    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_LCD    = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_bit_t;

    localparam int unsigned IRQ_COUNT = 5;
    localparam logic [15:0] IF_ADDR   = 16'hFF0F;
    localparam logic [15:0] IE_ADDR   = 16'hFFFF;
    localparam logic [7:0]  VEC_BASE  = 8'h40;

    // Interrupt controller sequencing states.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ISR  = 2'd2
    } irq_state_t;

    // Low byte of the jump target for source idx; vectors are 8 bytes apart.
    function automatic logic [7:0] irq_vector(input logic [7:0] base, input logic [2:0] idx);
        return base + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/gb_cpu_irq_priority.sv
// Lowest-index-first priority encoder over the pending interrupt set.
module gb_cpu_irq_priority #(
    parameter int unsigned NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               valid,
    output logic [2:0]         idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Interrupt and HALT controller: IF/IE/IME registers, EI delay, ISR dispatch
// towards the decoder, HALT sleep/wake and the halt-bug indication.
module gb_cpu_interrupt_ctrl #(
    parameter int unsigned NUM_IRQ  = 5,
    parameter logic [7:0]  VEC_BASE = gb_cpu_common_pkg::VEC_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [15:0]        bus_addr,
    input  logic [7:0]         bus_wdata,
    input  logic               bus_we,
    output logic [7:0]         bus_rdata,
    output logic               bus_hit,
    input  logic               instr_boundary,
    input  logic               ei_exec,
    input  logic               di_exec,
    input  logic               reti_exec,
    input  logic               halt_exec,
    input  logic               isr_ack,
    output logic               isr_cmd,
    output logic [7:0]         isr_vector,
    output logic               ime,
    output logic               halted,
    output logic               halt_bug
);

    import gb_cpu_common_pkg::*;

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_d;
    logic [7:0]         ie_q;
    logic               ime_q;
    logic               ei_pend_q;
    logic               isr_cmd_q;
    logic [7:0]         isr_vector_q;
    logic               halted_q;
    logic               halt_bug_q;
    irq_state_t         state_q;

    logic [NUM_IRQ-1:0] pending;
    logic               prio_valid;
    logic [2:0]         prio_idx;
    logic               any_pend;
    logic               ime_eff;
    logic               ack_take;
    logic               if_wr;
    logic               ie_wr;

    assign if_wr    = bus_we && (bus_addr == IF_ADDR);
    assign ie_wr    = bus_we && (bus_addr == IE_ADDR);
    assign pending  = ie_q[NUM_IRQ-1:0] & if_q;

    gb_cpu_irq_priority #(
        .NUM_IRQ (NUM_IRQ)
    ) u_priority (
        .pending (pending),
        .valid   (prio_valid),
        .idx     (prio_idx)
    );

    assign any_pend = prio_valid;
    // RETI enables and DI disables within the same boundary decision.
    assign ime_eff  = (ime_q | ei_pend_q | reti_exec) & ~di_exec;
    // Ack always services the live pending set, not what was pending at dispatch.
    assign ack_take = (state_q == ISR) && isr_ack && prio_valid;

    // IF next state: bus write, then ack clear, then peripheral sets win over both.
    always_comb begin
        if_d = if_q;
        if (if_wr) begin
            if_d = bus_wdata[NUM_IRQ-1:0];
        end
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (ack_take && (prio_idx == 3'(i))) begin
                if_d[i] = 1'b0;
            end
        end
        if_d = if_d | irq_in;
    end

    // IF and IE storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_q <= '0;
            ie_q <= 8'h00;
        end else begin
            if_q <= if_d;
            if (ie_wr) begin
                ie_q <= bus_wdata;
            end
        end
    end

    // Combinational register readback; unused IF bits read as 1.
    always_comb begin
        bus_rdata = 8'h00;
        bus_hit   = 1'b0;
        if (bus_addr == IF_ADDR) begin
            bus_hit                  = 1'b1;
            bus_rdata                = 8'hFF;
            bus_rdata[NUM_IRQ-1:0]   = if_q;
        end else if (bus_addr == IE_ADDR) begin
            bus_hit   = 1'b1;
            bus_rdata = ie_q;
        end
    end

    // RUN/HALT/ISR sequencing together with IME, EI delay and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            ime_q        <= 1'b0;
            ei_pend_q    <= 1'b0;
            isr_cmd_q    <= 1'b0;
            isr_vector_q <= 8'h00;
            halted_q     <= 1'b0;
            halt_bug_q   <= 1'b0;
        end else begin
            halt_bug_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (instr_boundary) begin
                        // A pending EI matures here; a fresh EI only arms the next boundary.
                        ime_q     <= ime_eff;
                        ei_pend_q <= ei_exec & ~di_exec;
                        if (halt_exec) begin
                            if (!ime_eff && any_pend) begin
                                halt_bug_q <= 1'b1;
                            end else begin
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end
                        end else if (ime_eff && any_pend) begin
                            isr_cmd_q <= 1'b1;
                            ime_q     <= 1'b0;
                            ei_pend_q <= 1'b0;
                            state_q   <= ISR;
                        end
                    end
                end
                HALT: begin
                    if (any_pend) begin
                        halted_q <= 1'b0;
                        if (ime_q) begin
                            isr_cmd_q <= 1'b1;
                            ime_q     <= 1'b0;
                            ei_pend_q <= 1'b0;
                            state_q   <= ISR;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                ISR: begin
                    if (isr_ack) begin
                        isr_vector_q <= prio_valid ? irq_vector(VEC_BASE, prio_idx) : 8'h00;
                        isr_cmd_q    <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign isr_cmd    = isr_cmd_q;
    assign isr_vector = isr_vector_q;
    assign ime        = ime_q;
    assign halted     = halted_q;
    assign halt_bug   = halt_bug_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
module tb_gb_cpu_interrupt_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  irq_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic [7:0]  bus_rdata;
    logic        bus_hit;
    logic        instr_boundary;
    logic        ei_exec;
    logic        di_exec;
    logic        reti_exec;
    logic        halt_exec;
    logic        isr_ack;
    logic        isr_cmd;
    logic [7:0]  isr_vector;
    logic        ime;
    logic        halted;
    logic        halt_bug;

    gb_cpu_interrupt_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_rdata      (bus_rdata),
        .bus_hit        (bus_hit),
        .instr_boundary (instr_boundary),
        .ei_exec        (ei_exec),
        .di_exec        (di_exec),
        .reti_exec      (reti_exec),
        .halt_exec      (halt_exec),
        .isr_ack        (isr_ack),
        .isr_cmd        (isr_cmd),
        .isr_vector     (isr_vector),
        .ime            (ime),
        .halted         (halted),
        .halt_bug       (halt_bug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = running, 1 = asleep in HALT, 2 = ISR requested.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic       m_ime;
    logic       m_ei;
    int         m_mode;
    logic [7:0] m_vec;
    logic       m_bug;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_if   = 5'h00;
        m_ie   = 8'h00;
        m_ime  = 1'b0;
        m_ei   = 1'b0;
        m_mode = 0;
        m_vec  = 8'h00;
        m_bug  = 1'b0;
    endtask

    task automatic model_update();
        int         n;
        logic       eff;
        logic [4:0] nif;
        logic [7:0] nie;
        logic       nime;
        logic       nei;
        int         nmode;
        logic [7:0] nvec;
        logic       nbug;
        if (rst) begin
            model_reset();
            return;
        end
        n     = first_set(m_ie[4:0] & m_if);
        eff   = (m_ime || m_ei || reti_exec) && !di_exec;
        nif   = m_if;
        nie   = m_ie;
        nime  = m_ime;
        nei   = m_ei;
        nmode = m_mode;
        nvec  = m_vec;
        nbug  = 1'b0;
        if (bus_we && bus_addr == 16'hFF0F) nif = bus_wdata[4:0];
        if (bus_we && bus_addr == 16'hFFFF) nie = bus_wdata;
        if (m_mode == 0 && instr_boundary) begin
            nime = eff;
            nei  = ei_exec && !di_exec;
            if (halt_exec) begin
                if (!eff && n >= 0) nbug = 1'b1;
                else nmode = 1;
            end else if (eff && n >= 0) begin
                nmode = 2;
                nime  = 1'b0;
                nei   = 1'b0;
            end
        end else if (m_mode == 1 && n >= 0) begin
            if (m_ime) begin
                nmode = 2;
                nime  = 1'b0;
                nei   = 1'b0;
            end else begin
                nmode = 0;
            end
        end else if (m_mode == 2 && isr_ack) begin
            nmode = 0;
            if (n >= 0) begin
                nvec   = 8'(8'h40 + 8 * n);
                nif[n] = 1'b0;
            end else begin
                nvec = 8'h00;
            end
        end
        nif    = nif | irq_in;
        m_if   = nif;
        m_ie   = nie;
        m_ime  = nime;
        m_ei   = nei;
        m_mode = nmode;
        m_vec  = nvec;
        m_bug  = nbug;
    endtask

    task automatic clear_in();
        rst            = 1'b0;
        irq_in         = 5'h00;
        bus_addr       = 16'h0000;
        bus_wdata      = 8'h00;
        bus_we         = 1'b0;
        instr_boundary = 1'b0;
        ei_exec        = 1'b0;
        di_exec        = 1'b0;
        reti_exec      = 1'b0;
        halt_exec      = 1'b0;
        isr_ack        = 1'b0;
    endtask

    // One clock with the inputs already driven; called and returning at negedge.
    task automatic tick();
        logic [7:0] exp_rd;
        if (rst) model_reset();
        #1;
        exp_rd = 8'h00;
        if (bus_addr == 16'hFF0F) exp_rd = {3'b111, m_if};
        else if (bus_addr == 16'hFFFF) exp_rd = m_ie;
        chk("bus_rdata", {8'h00, bus_rdata}, {8'h00, exp_rd});
        chk("bus_hit", {15'h0, bus_hit},
            {15'h0, (bus_addr == 16'hFF0F) || (bus_addr == 16'hFFFF)});
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("isr_cmd", {15'h0, isr_cmd}, {15'h0, m_mode == 2});
        chk("halted", {15'h0, halted}, {15'h0, m_mode == 1});
        chk("ime", {15'h0, ime}, {15'h0, m_ime});
        chk("isr_vector", {8'h00, isr_vector}, {8'h00, m_vec});
        chk("halt_bug", {15'h0, halt_bug}, {15'h0, m_bug});
        clear_in();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        tick();
    endtask

    task automatic bnd(input logic e, input logic d, input logic r, input logic h);
        instr_boundary = 1'b1;
        ei_exec        = e;
        di_exec        = d;
        reti_exec      = r;
        halt_exec      = h;
        tick();
    endtask

    task automatic ack();
        isr_ack = 1'b1;
        tick();
    endtask

    task automatic irq(input logic [4:0] v);
        irq_in = v;
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus_addr = a;
        bus_we   = 1'b0;
        #1;
        chk(name, {8'h00, bus_rdata}, {8'h00, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] exp_if;
        clear_in();
        model_reset();
        do_reset();
        chk("rst_isr_cmd", {15'h0, isr_cmd}, 16'h0);
        chk("rst_vector", {8'h00, isr_vector}, 16'h0);
        rd_chk("rst_if", 16'hFF0F, 8'hE0);

        // Timer interrupt enabled through EI.
        wr(16'hFFFF, 8'h04);
        irq(5'b00100);
        bnd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ei_delay_no_cmd", {15'h0, isr_cmd}, 16'h0);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        chk("timer_cmd", {15'h0, isr_cmd}, 16'h1);
        chk("timer_ime_off", {15'h0, ime}, 16'h0);
        ack();
        chk("timer_vec", {8'h00, isr_vector}, 16'h50);
        rd_chk("timer_if_clear", 16'hFF0F, 8'hE0);

        // All sources pending: serviced in priority order.
        wr(16'hFF0F, 8'h1F);
        wr(16'hFFFF, 8'h1F);
        for (int k = 0; k < 5; k++) begin
            bnd(1'b0, 1'b0, 1'b1, 1'b0);
            chk("prio_cmd", {15'h0, isr_cmd}, 16'h1);
            ack();
            chk("prio_vec", {8'h00, isr_vector}, 16'(8'h40 + 8 * k));
            exp_if = 8'hE0 | (8'h1F & (8'hFF << (k + 1)));
            rd_chk("prio_if", 16'hFF0F, exp_if);
        end

        // EI delay with a pending source, then DI cancelling a pending EI.
        wr(16'hFF0F, 8'h01);
        wr(16'hFFFF, 8'h01);
        bnd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ei_b0_no_cmd", {15'h0, isr_cmd}, 16'h0);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ei_b1_cmd", {15'h0, isr_cmd}, 16'h1);
        ack();
        chk("ei_vec", {8'h00, isr_vector}, 16'h40);
        wr(16'hFF0F, 8'h01);
        bnd(1'b1, 1'b0, 1'b0, 1'b0);
        bnd(1'b0, 1'b1, 1'b0, 1'b0);
        chk("di_no_cmd", {15'h0, isr_cmd}, 16'h0);
        chk("di_ime", {15'h0, ime}, 16'h0);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        chk("di_still_no_cmd", {15'h0, isr_cmd}, 16'h0);

        // HALT with IME clear: wake without dispatch.
        wr(16'hFF0F, 8'h00);
        bnd(1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt_enter", {15'h0, halted}, 16'h1);
        tick();
        irq(5'b00001);
        chk("halt_still", {15'h0, halted}, 16'h1);
        tick();
        chk("halt_wake", {15'h0, halted}, 16'h0);
        chk("halt_wake_no_cmd", {15'h0, isr_cmd}, 16'h0);
        rd_chk("halt_wake_if", 16'hFF0F, 8'hE1);

        // HALT with IME set: wake into the ISR.
        wr(16'hFF0F, 8'h00);
        bnd(1'b1, 1'b0, 1'b0, 1'b0);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        bnd(1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt2_enter", {15'h0, halted}, 16'h1);
        irq(5'b00001);
        tick();
        chk("halt2_wake", {15'h0, halted}, 16'h0);
        chk("halt2_cmd", {15'h0, isr_cmd}, 16'h1);
        ack();
        chk("halt2_vec", {8'h00, isr_vector}, 16'h40);

        // Halt bug: IME clear with something already pending.
        wr(16'hFF0F, 8'h02);
        wr(16'hFFFF, 8'h02);
        bnd(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hbug_pulse", {15'h0, halt_bug}, 16'h1);
        chk("hbug_not_halted", {15'h0, halted}, 16'h0);
        tick();
        chk("hbug_one_cycle", {15'h0, halt_bug}, 16'h0);

        // Peripheral set beats a bus write of zero.
        irq_in = 5'b00001;
        wr(16'hFF0F, 8'h00);
        rd_chk("set_beats_write", 16'hFF0F, 8'hE1);

        // IE cleared between dispatch and ack.
        wr(16'hFF0F, 8'h04);
        wr(16'hFFFF, 8'h04);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        chk("late_cmd", {15'h0, isr_cmd}, 16'h1);
        wr(16'hFFFF, 8'h00);
        ack();
        chk("late_vec_zero", {8'h00, isr_vector}, 16'h00);
        rd_chk("late_if_kept", 16'hFF0F, 8'hE4);

        // Reset while the ISR request is outstanding.
        wr(16'hFFFF, 8'h04);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_cmd", {15'h0, isr_cmd}, 16'h1);
        do_reset();
        chk("rst_isr_cmd2", {15'h0, isr_cmd}, 16'h0);
        rd_chk("rst_if2", 16'hFF0F, 8'hE0);
        rd_chk("rst_ie2", 16'hFFFF, 8'h00);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int sel;
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            for (int b = 0; b < 5; b++) irq_in[b] = ($urandom_range(0, 11) == 0);
            sel = int'($urandom_range(0, 2));
            bus_addr  = (sel == 0) ? 16'hFF0F : (sel == 1) ? 16'hFFFF : 16'($urandom);
            bus_wdata = 8'($urandom);
            bus_we    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) begin
                instr_boundary = 1'b1;
                sel = int'($urandom_range(0, 9));
                ei_exec   = (sel == 0 || sel == 1);
                di_exec   = (sel == 2);
                reti_exec = (sel == 3);
                halt_exec = (sel == 4);
            end
            if (m_mode == 2) isr_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
